fl: RTL and testbench

Physical-register free list for the R10K-style rename stage. Holds the physical registers not mapped in the architectural state. Supplies up to two free tags per cycle to the map table and rename logic as `fl_pr0`/`fl_pr1`. Reclaims the overwritten tags (`Told`) that the ROB releases at retirement.

---
 rtl/fl_pkg.sv | 12 +
 rtl/fl.sv | 98 +++++++++
 tb/tb_fl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fl_pkg.sv
// Shared rename-stage constants and the physical tag type used by the free list,
// map table and ROB.
package fl_pkg;

  localparam int PR_W     = 7;
  localparam int NUM_PR   = 64;
  localparam int NUM_AR   = 32;
  localparam int FL_DEPTH = NUM_PR - NUM_AR;

  typedef logic [PR_W-1:0] pr_tag_t;

endpackage

// File: rtl/fl.sv
// Physical-register free list: circular buffer supplying two tags per cycle and
// reclaiming retired Told tags. Optional mispredict recovery under FL_RECOVERY_EN.
module fl #(
  parameter int NUM_PR = fl_pkg::NUM_PR,
  parameter int NUM_AR = fl_pkg::NUM_AR,
  parameter int PR_W   = fl_pkg::PR_W
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [1:0]                             rob_dispatch_num,
  input  logic [1:0]                             rob_retire_num,
  input  logic [PR_W-1:0]                        rob_p0told,
  input  logic [PR_W-1:0]                        rob_p1told,
`ifdef FL_RECOVERY_EN
  input  logic                                   rob_mispredict,
`endif
  output logic [PR_W-1:0]                        fl_pr0,
  output logic [PR_W-1:0]                        fl_pr1,
  output logic [1:0]                             fl_free_num,
  output logic [$clog2(NUM_PR-NUM_AR):0]         fl_count
);

  localparam int DEPTH = NUM_PR - NUM_AR;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [PR_W-1:0] ring [DEPTH];
  ptr_t            head;
  ptr_t            tail;
  cnt_t            count;

  logic [1:0]      disp_eff;
  logic [1:0]      pop;
  logic [1:0]      push;
  cnt_t            room;
  cnt_t            count_next;
  ptr_t            tail_next;
  logic            recover;

  function automatic ptr_t ptr_inc(input ptr_t ptr, input logic [1:0] n);
    logic [PTR_W:0] sum;
    sum = {1'b0, ptr} + {{(PTR_W-1){1'b0}}, n};
    if (sum >= DEPTH[PTR_W:0]) sum = sum - DEPTH[PTR_W:0];
    return sum[PTR_W-1:0];
  endfunction

`ifdef FL_RECOVERY_EN
  assign recover = rob_mispredict;
`else
  assign recover = 1'b0;
`endif

  assign fl_pr0      = ring[head];
  assign fl_pr1      = ring[ptr_inc(head, 2'd1)];
  assign fl_free_num = (count >= cnt_t'(2)) ? 2'd2 : count[1:0];
  assign fl_count    = count;

  // Requests beyond availability are truncated; a retire overflowing the list
  // only accepts as many pushes as there are empty slots.
  always_comb begin
    disp_eff   = (rob_dispatch_num == 2'd3) ? 2'd2 : rob_dispatch_num;
    pop        = (disp_eff <= fl_free_num) ? disp_eff : fl_free_num;
    room       = cnt_t'(DEPTH) - count;
    push       = (cnt_t'(rob_retire_num) > room) ? room[1:0] : rob_retire_num;
    count_next = count - cnt_t'(pop) + cnt_t'(push);
    tail_next  = ptr_inc(tail, push);
  end

  // NOTE: the ring is reset like any other register because its initial contents
  // (tags NUM_AR..NUM_PR-1) are architecturally visible, not just the pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= PR_W'(NUM_AR + i);
      head  <= '0;
      tail  <= '0;
      count <= cnt_t'(DEPTH);
    end else begin
      overflow_chk: assert (cnt_t'(rob_retire_num) <= room)
        else $error("fl: retire of %0d tags overflows free list (count %0d)",
                    rob_retire_num, count);
      if (push != 2'd0) ring[tail] <= rob_p0told;
      if (push == 2'd2) ring[ptr_inc(tail, 2'd1)] <= rob_p1told;
      tail <= tail_next;
      // Recovery returns every slot in [tail, head), i.e. all in-flight tags.
      if (recover) begin
        head  <= tail_next;
        count <= cnt_t'(DEPTH);
      end else begin
        head  <= ptr_inc(head, pop);
        count <= count_next;
      end
    end
  end

endmodule

// File: tb/tb_fl.sv
// Self-checking bench for fl: directed vector table, wrap-around and randomized
// runs against a queue model, and asynchronous reset during traffic.
module tb_fl;
  import fl_pkg::*;

  localparam int CW = $clog2(FL_DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    rob_dispatch_num;
  logic [1:0]    rob_retire_num;
  pr_tag_t       rob_p0told;
  pr_tag_t       rob_p1told;
  logic          rob_mispredict;
  pr_tag_t       fl_pr0;
  pr_tag_t       fl_pr1;
  logic [1:0]    fl_free_num;
  logic [CW-1:0] fl_count;

  int checks = 0;
  int errors = 0;

  pr_tag_t q[$];
  pr_tag_t hist[$];

  typedef struct {
    logic [1:0] disp;
    logic [1:0] ret;
    pr_tag_t    t0;
    pr_tag_t    t1;
    logic       chk0;
    logic       chk1;
    pr_tag_t    e0;
    pr_tag_t    e1;
    logic [1:0] efree;
    int         ecnt;
  } vec_t;

  vec_t vecs [22];

  fl dut (
    .clock            (clock),
    .reset            (reset),
    .rob_dispatch_num (rob_dispatch_num),
    .rob_retire_num   (rob_retire_num),
    .rob_p0told       (rob_p0told),
    .rob_p1told       (rob_p1told),
`ifdef FL_RECOVERY_EN
    .rob_mispredict   (rob_mispredict),
`endif
    .fl_pr0           (fl_pr0),
    .fl_pr1           (fl_pr1),
    .fl_free_num      (fl_free_num),
    .fl_count         (fl_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    check({tag, " count"}, 32'(fl_count), n);
    check({tag, " free"}, 32'(fl_free_num), (n >= 2) ? 2 : n);
    if (n >= 1) check({tag, " pr0"}, 32'(fl_pr0), 32'(q[0]));
    if (n >= 2) check({tag, " pr1"}, 32'(fl_pr1), 32'(q[1]));
  endtask

  // Applies one cycle of stimulus, advances the queue model, ends at the next negedge.
  task automatic drive(input logic [1:0] d, input logic [1:0] r,
                       input pr_tag_t t0, input pr_tag_t t1, input logic m);
    int want;
    int npop;
    pr_tag_t rebuilt[$];
    rob_dispatch_num = d;
    rob_retire_num   = r;
    rob_p0told       = t0;
    rob_p1told       = t1;
    rob_mispredict   = m;
    if (m) begin
      if (r >= 1) q.push_back(t0);
      if (r == 2) q.push_back(t1);
      want = FL_DEPTH - q.size();
      for (int i = hist.size() - want; i < hist.size(); i++) rebuilt.push_back(hist[i]);
      foreach (q[i]) rebuilt.push_back(q[i]);
      q = rebuilt;
    end else begin
      want = (d == 3) ? 2 : int'(d);
      npop = (want < q.size()) ? want : q.size();
      for (int i = 0; i < npop; i++) begin
        hist.push_back(q.pop_front());
        if (hist.size() > FL_DEPTH) void'(hist.pop_front());
      end
      if (r >= 1) q.push_back(t0);
      if (r == 2) q.push_back(t1);
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rob_dispatch_num = 2'd0;
    rob_retire_num   = 2'd0;
    rob_mispredict   = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    hist.delete();
    for (int i = 0; i < FL_DEPTH; i++) q.push_back(pr_tag_t'(32 + i));
  endtask

  initial begin
    int maxr;
    // Directed table: expected outputs present during the cycle the inputs are applied.
    for (int i = 0; i < 16; i++)
      vecs[i] = '{2'd2, 2'd0, 7'd0, 7'd0, 1'b1, 1'b1,
                  pr_tag_t'(32 + 2*i), pr_tag_t'(33 + 2*i), 2'd2, 32 - 2*i};
    vecs[16] = '{2'd0, 2'd2, 7'd5, 7'd6, 1'b0, 1'b0, 7'd0, 7'd0, 2'd0, 0};
    vecs[17] = '{2'd1, 2'd0, 7'd0, 7'd0, 1'b1, 1'b1, 7'd5, 7'd6, 2'd2, 2};
    vecs[18] = '{2'd2, 2'd1, 7'd9, 7'd0, 1'b1, 1'b0, 7'd6, 7'd0, 2'd1, 1};
    vecs[19] = '{2'd0, 2'd0, 7'd0, 7'd0, 1'b1, 1'b0, 7'd9, 7'd0, 2'd1, 1};
    vecs[20] = '{2'd3, 2'd0, 7'd0, 7'd0, 1'b1, 1'b0, 7'd9, 7'd0, 2'd1, 1};
    vecs[21] = '{2'd0, 2'd0, 7'd0, 7'd0, 1'b0, 1'b0, 7'd0, 7'd0, 2'd0, 0};

    reset = 1'b1;
    rob_dispatch_num = 2'd0;
    rob_retire_num   = 2'd0;
    rob_p0told       = '0;
    rob_p1told       = '0;
    rob_mispredict   = 1'b0;
    @(negedge clock);
    check("reset pr0", 32'(fl_pr0), 32);
    check("reset pr1", 32'(fl_pr1), 33);
    check("reset free", 32'(fl_free_num), 2);
    check("reset count", 32'(fl_count), 32);
    reset = 1'b0;

    foreach (vecs[i]) begin
      check($sformatf("vec%0d count", i), 32'(fl_count), vecs[i].ecnt);
      check($sformatf("vec%0d free", i), 32'(fl_free_num), 32'(vecs[i].efree));
      if (vecs[i].chk0) check($sformatf("vec%0d pr0", i), 32'(fl_pr0), 32'(vecs[i].e0));
      if (vecs[i].chk1) check($sformatf("vec%0d pr1", i), 32'(fl_pr1), 32'(vecs[i].e1));
      drive(vecs[i].disp, vecs[i].ret, vecs[i].t0, vecs[i].t1, 1'b0);
    end

    // Steady dispatch 2 / retire 2: head and tail both cross the 31->0 boundary.
    do_reset();
    drive(2'd2, 2'd0, 7'd0, 7'd0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      check_model($sformatf("wrap%0d", i));
      check($sformatf("wrap%0d steady", i), 32'(fl_count), 30);
      drive(2'd2, 2'd2, pr_tag_t'(2*i), pr_tag_t'(2*i + 1), 1'b0);
    end
    check_model("wrap end");

    // Randomized traffic, retire kept within capacity.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      check_model($sformatf("rand%0d", i));
      maxr = FL_DEPTH - q.size();
      if (maxr > 2) maxr = 2;
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, maxr)),
            pr_tag_t'($urandom), pr_tag_t'($urandom), 1'b0);
    end
    check_model("rand end");

`ifdef FL_RECOVERY_EN
    do_reset();
    for (int i = 0; i < 5; i++) drive(2'd2, 2'd0, 7'd0, 7'd0, 1'b0);
    check_model("pre-recover");
    drive(2'd2, 2'd1, 7'd12, 7'd0, 1'b1);
    check("recover count", 32'(fl_count), 32);
    check("recover pr0", 32'(fl_pr0), 33);
    check_model("recover");
    for (int i = 0; i < 40; i++) begin
      maxr = FL_DEPTH - q.size();
      if (maxr > 2) maxr = 2;
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, maxr)),
            pr_tag_t'($urandom), pr_tag_t'($urandom), 1'($urandom_range(0, 7) == 0));
      check_model($sformatf("rec rand%0d", i));
    end
`endif

    // Asynchronous reset in the middle of a dispatch+retire cycle.
    rob_dispatch_num = 2'd2;
    rob_retire_num   = (q.size() <= FL_DEPTH - 2) ? 2'd2 : 2'd0;
    rob_p0told       = 7'd100;
    rob_p1told       = 7'd101;
    #2 reset = 1'b1;
    #1;
    check("midreset pr0", 32'(fl_pr0), 32);
    check("midreset pr1", 32'(fl_pr1), 33);
    check("midreset free", 32'(fl_free_num), 2);
    check("midreset count", 32'(fl_count), 32);
    @(negedge clock);
    check("midreset hold count", 32'(fl_count), 32);
    reset = 1'b0;
    rob_dispatch_num = 2'd0;
    rob_retire_num   = 2'd0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
